// File: rtl/csla_64bit.sv
// 64-bit carry-select adder: 16 four-bit blocks built from full-adder ripple chains,
// with a single output register stage holding {cout, sum}.
module csla_64bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    // 4-bit ripple adder from full-adder cells; returns {carry_out, sum[3:0]}
    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c);
        logic [4:0] cc;
        logic [3:0] s;
        cc[0] = c;
        for (int i = 0; i < 4; i++) begin
            s[i]    = x[i] ^ y[i] ^ cc[i];
            cc[i+1] = (x[i] & y[i]) | (x[i] & cc[i]) | (y[i] & cc[i]);
        end
        return {cc[4], s};
    endfunction

    // Stage p0: combinational carry-select core
    logic [16:0] blk_c;
    logic [63:0] sum_p0;

    assign blk_c[0] = cin;
    assign {blk_c[1], sum_p0[3:0]} = rca4(a[3:0], b[3:0], cin);

    for (genvar k = 1; k < 16; k++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0 = rca4(a[4*k +: 4], b[4*k +: 4], 1'b0);
        assign r1 = rca4(a[4*k +: 4], b[4*k +: 4], 1'b1);
        assign {blk_c[k+1], sum_p0[4*k +: 4]} = blk_c[k] ? r1 : r0;
    end

    // Stage p1: output register
    logic [63:0] sum_p1;
    logic        cout_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= 64'h0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum_p0;
            cout_p1 <= blk_c[16];
        end
    end

    assign sum  = sum_p1;
    assign cout = cout_p1;

endmodule

// File: tb/tb_csla_64bit.sv
// Scoreboard bench for csla_64bit: directed vectors, reset behaviour and random
// operands checked against a 65-bit arithmetic reference with one-cycle alignment.
module tb_csla_64bit;

    logic        clk;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;

    csla_64bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [64:0] expq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got cout=%0b sum=%h, required cout=%0b sum=%h",
                     name, act[64], act[63:0], exp[64], exp[63:0]);
        end
    endtask

    function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y,
                                            input logic c);
        logic [64:0] r;
        r = {1'b0, x} + {1'b0, y} + {64'h0, c};
        return r;
    endfunction

    // Apply inputs between edges and queue the result expected after the next edge
    task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic c,
                         input logic [64:0] exp);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = c;
        expq.push_back(exp);
    endtask

    // Monitor: each active edge out of reset retires one queued expectation
    always @(posedge clk) begin
        if (rst_n && expq.size() > 0) begin
            logic [64:0] e;
            e = expq.pop_front();
            #1;
            check("scoreboard", {cout, sum}, e);
        end
    end

    initial begin
        rst_n = 1'b0;
        a     = 64'h0;
        b     = 64'h0;
        cin   = 1'b0;
        #12;
        check("reset_initial", {cout, sum}, 65'h0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(64'd10, 64'd35, 1'b0, 65'd45);
        drive(64'd23, 64'd132, 1'b1, 65'd156);
        drive(64'd3846, 64'd9654, 1'b0, 65'd13500);
        drive(64'd866945, 64'd3324752, 1'b1, 65'd4191698);
        drive(64'd6223372036854775808, 64'd38701384792384, 1'b1, 65'd6223410738239568193);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, {1'b1, 64'h0});

        // Pending result discarded by an asynchronous reset between edges
        drive(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 65'h0);
        void'(expq.pop_back());
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", {cout, sum}, 65'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom);
            #2;
            check("reset_hold", {cout, sum}, 65'h0);
        end
        @(negedge clk);
        a     = 64'hFFFF_FFFF_0000_0001;
        b     = 64'h0000_0001_FFFF_FFFF;
        cin   = 1'b0;
        rst_n = 1'b1;
        expq.push_back(ref_sum(a, b, cin));

        for (int i = 0; i < 10000; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            logic        c;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            c = 1'($urandom);
            drive(x, y, c, ref_sum(x, y, c));
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
